// File: rtl/myip_stopwatch_pkg.sv
// Shared definitions for the stopwatch AXI4-Lite slave: register map, CTRL layout, helpers.
package myip_stopwatch_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned STRB_W = DATA_W / 8;

  localparam logic [ADDR_W-1:0] ADDR_CTRL     = 4'h0;
  localparam logic [ADDR_W-1:0] ADDR_PRESCALE = 4'h4;
  localparam logic [ADDR_W-1:0] ADDR_COUNT    = 4'h8;
  localparam logic [ADDR_W-1:0] ADDR_LAP      = 4'hC;

  // Word selects; byte offset bits [1:0] are ignored by the decode
  localparam logic [1:0] SEL_CTRL     = ADDR_CTRL[3:2];
  localparam logic [1:0] SEL_PRESCALE = ADDR_PRESCALE[3:2];
  localparam logic [1:0] SEL_COUNT    = ADDR_COUNT[3:2];
  localparam logic [1:0] SEL_LAP      = ADDR_LAP[3:2];

  localparam int unsigned RUN_BIT = 0;
  localparam int unsigned CLR_BIT = 1;
  localparam int unsigned LAP_BIT = 2;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef struct packed {
    logic lap;
    logic clr;
    logic run;
  } ctrl_t;

  function automatic logic [DATA_W-1:0] apply_wstrb(input logic [DATA_W-1:0] old_v,
                                                    input logic [DATA_W-1:0] new_v,
                                                    input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] r;
    r = old_v;
    for (int unsigned i = 0; i < STRB_W; i++) begin
      if (strb[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/myip_stopwatch_core.sv
// Stopwatch timebase: prescaler, elapsed COUNT and optional lap capture.
// Lap capture flop exists only when MYIP_STOPWATCH_LAP_EN is defined; otherwise lap reads 0.
module myip_stopwatch_core
  import myip_stopwatch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              clr_pulse,
  input  logic              lap_pulse,
  input  logic [DATA_W-1:0] prescale,
  output logic [DATA_W-1:0] count,
  output logic [DATA_W-1:0] lap
);

  logic [DATA_W-1:0] psc_q, psc_d;
  logic [DATA_W-1:0] count_q, count_d;

  // Clear wins over counting; a prescale shrunk below the running count restarts without a tick
  always_comb begin
    psc_d   = psc_q;
    count_d = count_q;
    if (clr_pulse) begin
      psc_d   = '0;
      count_d = '0;
    end else if (run) begin
      if (psc_q > prescale) begin
        psc_d = '0;
      end else if (psc_q == prescale) begin
        psc_d   = '0;
        count_d = count_q + DATA_W'(1);
      end else begin
        psc_d = psc_q + DATA_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psc_q   <= '0;
      count_q <= '0;
    end else begin
      psc_q   <= psc_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;

`ifdef MYIP_STOPWATCH_LAP_EN
  logic [DATA_W-1:0] lap_q, lap_d;

  // Captures the pre-clear COUNT of the handshake cycle
  always_comb begin
    lap_d = lap_q;
    if (lap_pulse) lap_d = count_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lap_q <= '0;
    else     lap_q <= lap_d;
  end

  assign lap = lap_q;
`else
  logic unused_lap_pulse;
  assign unused_lap_pulse = lap_pulse;
  assign lap = '0;
`endif

endmodule

// File: rtl/myip_stopwatch_s00_axi_slave.sv
// AXI4-Lite slave shell for the stopwatch: handshakes, register decode and read mux.
// LAP register content depends on MYIP_STOPWATCH_LAP_EN (see myip_stopwatch_core).
module myip_stopwatch_s00_axi_slave
  import myip_stopwatch_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   count_o
);

  logic              awready_q, awready_d;
  logic              bvalid_q, bvalid_d;
  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              run_q, run_d;
  logic [DATA_W-1:0] prescale_q, prescale_d;

  logic              wr_en_c, rd_en_c, ctrl_wr_c;
  logic              clr_pulse_c, lap_pulse_c;
  logic [1:0]        wr_sel_c, rd_sel_c;
  ctrl_t             wr_ctrl_c, rd_ctrl_c;
  logic [DATA_W-1:0] count_c, lap_c, rd_mux_c;

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign wr_sel_c    = S_AXI_AWADDR[3:2];
  assign rd_sel_c    = S_AXI_ARADDR[3:2];
  assign wr_en_c     = awready_q && S_AXI_AWVALID && S_AXI_WVALID;
  assign rd_en_c     = arready_q && S_AXI_ARVALID;
  assign wr_ctrl_c   = ctrl_t'(S_AXI_WDATA[2:0]);
  assign ctrl_wr_c   = wr_en_c && (wr_sel_c == SEL_CTRL) && S_AXI_WSTRB[0];
  assign clr_pulse_c = ctrl_wr_c && wr_ctrl_c.clr;
  assign lap_pulse_c = ctrl_wr_c && wr_ctrl_c.lap;

  // Write channel: AW and W accepted together, blocked while a response is pending
  always_comb begin
    awready_d = 1'b0;
    bvalid_d  = bvalid_q;
    if (!awready_q && S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q) awready_d = 1'b1;
    if (wr_en_c)                    bvalid_d = 1'b1;
    else if (bvalid_q && S_AXI_BREADY) bvalid_d = 1'b0;
  end

  // Register updates; COUNT and LAP are read-only and writes to them are dropped
  always_comb begin
    run_d      = run_q;
    prescale_d = prescale_q;
    if (ctrl_wr_c) run_d = wr_ctrl_c.run;
    if (wr_en_c && (wr_sel_c == SEL_PRESCALE))
      prescale_d = apply_wstrb(prescale_q, S_AXI_WDATA, S_AXI_WSTRB);
  end

  always_comb begin
    rd_ctrl_c = '{lap: 1'b0, clr: 1'b0, run: run_q};
    case (rd_sel_c)
      SEL_CTRL:     rd_mux_c = DATA_W'(rd_ctrl_c);
      SEL_PRESCALE: rd_mux_c = prescale_q;
      SEL_COUNT:    rd_mux_c = count_c;
      SEL_LAP:      rd_mux_c = lap_c;
      default:      rd_mux_c = '0;
    endcase
  end

  // Read channel: data sampled at the AR handshake, so a same-cycle write is not visible
  always_comb begin
    arready_d = 1'b0;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    if (S_AXI_ARVALID && !rvalid_q && !arready_q) arready_d = 1'b1;
    if (rd_en_c) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_mux_c;
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      awready_q  <= 1'b0;
      bvalid_q   <= 1'b0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      run_q      <= 1'b0;
      prescale_q <= '0;
    end else begin
      awready_q  <= awready_d;
      bvalid_q   <= bvalid_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      run_q      <= run_d;
      prescale_q <= prescale_d;
    end
  end

  myip_stopwatch_core u_core (
    .clk       (S_AXI_ACLK),
    .rst       (S_AXI_ARESET),
    .run       (run_q),
    .clr_pulse (clr_pulse_c),
    .lap_pulse (lap_pulse_c),
    .prescale  (prescale_q),
    .count     (count_c),
    .lap       (lap_c)
  );

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = RESP_OKAY;
  assign count_o       = count_c;

endmodule
